rvsteel_uart_receiver: RTL

RVSTEEL_UART_RECEIVER -- requirements
Module: rvsteel_uart_receiver

---
 rtl/rvsteel_uart_pkg.sv | 15 +
 rtl/rvsteel_uart_rx_sync.sv | 21 ++
 rtl/rvsteel_uart_receiver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rvsteel_uart_pkg.sv
// Shared types and constants for the RVSteel UART receiver.
package rvsteel_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int COUNTER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rvsteel_uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle (high) level.
module rvsteel_uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic serial_in,
    output logic serial_sync
);

    logic stage1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage1      <= 1'b1;
            serial_sync <= 1'b1;
        end else begin
            stage1      <= serial_in;
            serial_sync <= stage1;
        end
    end

endmodule

// File: rtl/rvsteel_uart_receiver.sv
// UART receiver, 8N1 by default; define RVSTEEL_UART_RX_PARITY_EN for an even-parity bit.
// Output byte is held with a valid/ready handshake; overrun and frame_error are one-cycle pulses.
module rvsteel_uart_receiver
    import rvsteel_uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam logic [COUNTER_W-1:0] HALF_BIT_LOAD = COUNTER_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [COUNTER_W-1:0] FULL_BIT_LOAD = COUNTER_W'(CYCLES_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 line;
    logic                 line_prev;
    rx_state_t            state, next_state;
    logic [COUNTER_W-1:0] counter, counter_next;
    logic [2:0]           bit_index, bit_index_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 counter_done;
    logic                 load_p0, load_next;
    logic                 error_p0, error_next;
    logic                 parity_ok;

    rvsteel_uart_rx_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (uart_rx),
        .serial_sync (line)
    );

    assign counter_done = (counter == '0);

`ifdef RVSTEEL_UART_RX_PARITY_EN
    logic parity_ok_next;
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        next_state     = state;
        counter_next   = counter;
        bit_index_next = bit_index;
        shift_next     = shift;
        load_next      = 1'b0;
        error_next     = 1'b0;
`ifdef RVSTEEL_UART_RX_PARITY_EN
        parity_ok_next = parity_ok;
`endif
        case (state)
            IDLE: begin
                // line_prev guards against a held-low (break) line retriggering
                if (line_prev && !line) begin
                    next_state   = START;
                    counter_next = HALF_BIT_LOAD;
                end
            end
            START: begin
                if (!counter_done) begin
                    counter_next = counter - 1'b1;
                end else if (!line) begin
                    next_state     = DATA;
                    counter_next   = FULL_BIT_LOAD;
                    bit_index_next = '0;
                end else begin
                    next_state = IDLE;
                end
            end
            DATA: begin
                if (!counter_done) begin
                    counter_next = counter - 1'b1;
                end else begin
                    shift_next     = {line, shift[DATA_BITS-1:1]};
                    counter_next   = FULL_BIT_LOAD;
                    bit_index_next = bit_index + 1'b1;
                    if (bit_index == LAST_BIT) begin
`ifdef RVSTEEL_UART_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end
            end
`ifdef RVSTEEL_UART_RX_PARITY_EN
            PARITY: begin
                if (!counter_done) begin
                    counter_next = counter - 1'b1;
                end else begin
                    parity_ok_next = ~(^shift ^ line);
                    counter_next   = FULL_BIT_LOAD;
                    next_state     = STOP;
                end
            end
`endif
            STOP: begin
                if (!counter_done) begin
                    counter_next = counter - 1'b1;
                end else begin
                    next_state = IDLE;
                    if (line && parity_ok) begin
                        load_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            bit_index <= '0;
            line_prev <= 1'b1;
            load_p0   <= 1'b0;
            error_p0  <= 1'b0;
`ifdef RVSTEEL_UART_RX_PARITY_EN
            parity_ok <= 1'b1;
`endif
        end else begin
            state     <= next_state;
            counter   <= counter_next;
            bit_index <= bit_index_next;
            line_prev <= line;
            load_p0   <= load_next;
            error_p0  <= error_next;
`ifdef RVSTEEL_UART_RX_PARITY_EN
            parity_ok <= parity_ok_next;
`endif
        end
    end

    always_ff @(posedge clock) begin
        shift <= shift_next;
    end

    // Output stage: stop-bit decision lands here one cycle after the sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= error_p0;
            overrun     <= load_p0 && rx_valid && !rx_ready;
            if (load_p0) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
